// File: rtl/bsg_10b_symbol_aligner_if.sv
// Handshake bundle between the serial bit source and the 10b symbol aligner.
interface bsg_10b_symbol_aligner_if;
  logic       bit_i;
  logic       v_i;
  logic       realign_i;
  logic [9:0] data_o;
  logic       v_o;
  logic       err_o;
  logic       locked_o;

  modport master (
    output bit_i, v_i, realign_i,
    input  data_o, v_o, err_o, locked_o
  );

  modport slave (
    input  bit_i, v_i, realign_i,
    output data_o, v_o, err_o, locked_o
  );
endinterface

// File: rtl/bsg_10b_symbol_aligner.sv
// Serial-to-parallel 10b symbol aligner: hunts for the symbol boundary using
// the half-weight rules of the balanced code, confirms it over several
// symbols, then emits aligned symbols with an error flag until too many
// consecutive invalid symbols force a re-hunt.
module bsg_10b_symbol_aligner #(
  parameter int lock_count_p   = 4,
  parameter int unlock_count_p = 4
) (
  input logic clk_i,
  input logic reset_i,
  bsg_10b_symbol_aligner_if.slave bus
);

  localparam int GOOD_W = $clog2(lock_count_p + 1);
  localparam int BAD_W  = $clog2(unlock_count_p + 1);
  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(lock_count_p - 1);
  localparam logic [BAD_W-1:0]  BAD_LAST  = BAD_W'(unlock_count_p - 1);

  typedef enum logic [1:0] {HUNT = 2'd0, CHECK = 2'd1, LOCKED = 2'd2} state_t;

  function automatic logic [2:0] pop5(input logic [4:0] x);
    return 3'(x[4]) + 3'(x[3]) + 3'(x[2]) + 3'(x[1]) + 3'(x[0]);
  endfunction

  // Legal (upper, lower) half weights, written as octal digit pairs.
  function automatic logic sym_valid(input logic [9:0] w);
    case ({pop5(w[9:5]), pop5(w[4:0])})
      6'o32, 6'o23, 6'o41, 6'o14, 6'o33: return 1'b1;
      default:                           return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] fill_sat(input logic [3:0] f);
    return (f == 4'd10) ? f : f + 4'd1;
  endfunction

  state_t            state;
  logic [8:0]        hist;      // nine most recent bits; the tenth is bit_i
  logic [3:0]        fill;
  logic [3:0]        ph_cnt;
  logic [GOOD_W-1:0] good_cnt;
  logic [BAD_W-1:0]  bad_cnt;
  logic [9:0]        data_p1;
  logic              vld_p1;
  logic              err_p1;
  logic              locked_p1;

  logic [9:0] window;
  logic       win_ok;
  logic       boundary;
  logic       fill_ok;

  assign window   = {hist, bus.bit_i};
  assign win_ok   = sym_valid(window);
  assign boundary = (ph_cnt == 4'd9);
  assign fill_ok  = (fill >= 4'd9);   // current bit is the 10th or later

  assign bus.data_o   = data_p1;
  assign bus.v_o      = vld_p1;
  assign bus.err_o    = err_p1;
  assign bus.locked_o = locked_p1;

  // Shift/phase tracking plus the HUNT/CHECK/LOCKED state machine with registered outputs.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state     <= HUNT;
      hist      <= '0;
      fill      <= '0;
      ph_cnt    <= '0;
      good_cnt  <= '0;
      bad_cnt   <= '0;
      data_p1   <= '0;
      vld_p1    <= 1'b0;
      err_p1    <= 1'b0;
      locked_p1 <= 1'b0;
    end else begin
      vld_p1 <= 1'b0;
      if (bus.v_i) begin
        hist   <= window[8:0];
        fill   <= fill_sat(fill);
        ph_cnt <= boundary ? 4'd0 : ph_cnt + 4'd1;
      end
      if (bus.realign_i) begin
        // The bit of this cycle is shifted in above but never evaluated.
        state     <= HUNT;
        good_cnt  <= '0;
        bad_cnt   <= '0;
        locked_p1 <= 1'b0;
      end else if (bus.v_i) begin
        unique case (state)
          HUNT: begin
            if (fill_ok && win_ok) begin
              ph_cnt <= 4'd0;
              if (lock_count_p == 1) begin
                state     <= LOCKED;
                bad_cnt   <= '0;
                locked_p1 <= 1'b1;
              end else begin
                state    <= CHECK;
                good_cnt <= GOOD_W'(1);
              end
            end
          end
          CHECK: begin
            if (boundary) begin
              if (!win_ok) begin
                // Slip: hunting restarts on the following bit.
                state <= HUNT;
              end else if (good_cnt == GOOD_LAST) begin
                state     <= LOCKED;
                bad_cnt   <= '0;
                locked_p1 <= 1'b1;
              end else begin
                good_cnt <= good_cnt + GOOD_W'(1);
              end
            end
          end
          LOCKED: begin
            if (boundary) begin
              data_p1 <= window;
              vld_p1  <= 1'b1;
              err_p1  <= !win_ok;
              if (win_ok) begin
                bad_cnt <= '0;
              end else if (bad_cnt == BAD_LAST) begin
                state     <= HUNT;
                locked_p1 <= 1'b0;
              end else begin
                bad_cnt <= bad_cnt + BAD_W'(1);
              end
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bsg_10b_symbol_aligner.sv
// Self-checking bench for bsg_10b_symbol_aligner: directed scenarios plus
// randomized streams compared cycle by cycle against a behavioural model.
module tb_bsg_10b_symbol_aligner;

  localparam int LOCK   = 4;
  localparam int UNLOCK = 4;

  logic clk = 1'b0;
  logic reset;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  bsg_10b_symbol_aligner_if ifc ();

  bsg_10b_symbol_aligner #(
    .lock_count_p  (LOCK),
    .unlock_count_p(UNLOCK)
  ) dut (
    .clk_i  (clk),
    .reset_i(reset),
    .bus    (ifc.slave)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // Tracks absolute bit positions since reset; the next expected boundary is
  // an absolute bit index rather than a phase counter.
  int         m_mode;      // 0 hunting, 1 confirming, 2 locked
  int         m_nbits;
  int         m_next_bd;
  int         m_good;
  int         m_bad;
  logic [9:0] m_win;
  logic       e_locked, e_v, e_err;
  logic [9:0] e_data;

  typedef struct packed {logic b; logic v; logic rl;} stim_t;
  stim_t stim_q[$];

  // A symbol is legal when its total weight is 5 without one half carrying
  // all of it, or when both halves weigh 3.
  function automatic bit m_valid(logic [9:0] w);
    int hi, lo;
    hi = 0; lo = 0;
    for (int i = 0; i < 5; i++) begin
      hi += int'(w[i+5]);
      lo += int'(w[i]);
    end
    return ((hi + lo == 5) && hi >= 1 && hi <= 4) || (hi == 3 && lo == 3);
  endfunction

  task automatic model_update(input logic b, input logic v, input logic rl, input logic rs);
    int idx;
    bit ok;
    if (rs) begin
      m_win = '0; m_nbits = 0; m_mode = 0; m_good = 0; m_bad = 0; m_next_bd = 0;
      e_locked = 1'b0; e_v = 1'b0; e_err = 1'b0; e_data = '0;
    end else begin
      e_v = 1'b0;
      if (v) begin
        m_win = {m_win[8:0], b};
        m_nbits++;
      end
      if (rl) begin
        m_mode = 0; m_good = 0; m_bad = 0; e_locked = 1'b0;
      end else if (v) begin
        idx = m_nbits - 1;
        ok  = m_valid(m_win);
        if (m_mode == 0) begin
          if (idx >= 9 && ok) begin
            m_next_bd = idx + 10;
            if (LOCK == 1) begin m_mode = 2; m_bad = 0; e_locked = 1'b1; end
            else begin m_mode = 1; m_good = 1; end
          end
        end else if (m_mode == 1) begin
          if (idx == m_next_bd) begin
            m_next_bd += 10;
            if (!ok) m_mode = 0;
            else begin
              m_good++;
              if (m_good == LOCK) begin m_mode = 2; m_bad = 0; e_locked = 1'b1; end
            end
          end
        end else begin
          if (idx == m_next_bd) begin
            m_next_bd += 10;
            e_v = 1'b1; e_data = m_win; e_err = !ok;
            if (ok) m_bad = 0;
            else begin
              m_bad++;
              if (m_bad == UNLOCK) begin m_mode = 0; e_locked = 1'b0; end
            end
          end
        end
      end
    end
  endtask

  // ---------------- stimulus helpers ----------------
  function automatic void push_bit(logic b, logic v, logic rl);
    stim_t t;
    t.b = b; t.v = v; t.rl = rl;
    stim_q.push_back(t);
  endfunction

  function automatic void add_sym(logic [9:0] sym);
    for (int i = 9; i >= 0; i--) push_bit(sym[i], 1'b1, 1'b0);
  endfunction

  function automatic void add_idle(int n);
    for (int i = 0; i < n; i++) push_bit(1'($urandom_range(0, 1)), 1'b0, 1'b0);
  endfunction

  task automatic step(input logic b, input logic v, input logic rl, input logic rs);
    @(negedge clk);
    ifc.bit_i = b; ifc.v_i = v; ifc.realign_i = rl; reset = rs;
    model_update(b, v, rl, rs);
    @(posedge clk);
    #1;
  endtask

  function automatic string got_s();
    return $sformatf("lock=%b v=%b err=%b data=%h", ifc.locked_o, ifc.v_o, ifc.err_o, ifc.data_o);
  endfunction

  function automatic string want_s();
    return $sformatf("lock=%b v=%b err=%b data=%h", e_locked, e_v, e_err, e_data);
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b1);
      total_cnt++;
      if ({ifc.locked_o, ifc.v_o, ifc.err_o, ifc.data_o} !== 13'h0)
        $display("FAIL reset cyc %0d: got %s, required all zero", i, got_s());
      else pass_cnt++;
    end
  endtask

  task automatic test_clean_lock();
    stim_t s;
    int n, strobes;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) add_sym(10'h343);
    n = 0; strobes = 0;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      step(s.b, s.v, s.rl, 1'b0);
      total_cnt++;
      if (ifc.locked_o !== e_locked || ifc.v_o !== e_v || ifc.data_o !== e_data || (e_v && ifc.err_o !== e_err))
        $display("FAIL clean_lock bit %0d: got %s want %s", n, got_s(), want_s());
      else pass_cnt++;
      if (n == 38 || n == 39) begin
        total_cnt++;
        if (ifc.locked_o !== (n == 39)) $display("FAIL clean_lock_rise bit %0d: locked=%b want %b", n, ifc.locked_o, (n == 39));
        else pass_cnt++;
      end
      if (ifc.v_o === 1'b1) begin
        strobes++;
        total_cnt++;
        if (ifc.data_o !== 10'h343 || ifc.err_o !== 1'b0)
          $display("FAIL clean_lock_data bit %0d: data=%h err=%b want 343/0", n, ifc.data_o, ifc.err_o);
        else pass_cnt++;
      end
      n++;
    end
    total_cnt++;
    if (strobes !== 4) $display("FAIL clean_lock_strobes: got %0d want 4", strobes);
    else pass_cnt++;
  endtask

  task automatic test_offset();
    stim_t s;
    int n, strobes;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) push_bit(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) add_sym(10'h343);
    n = 0; strobes = 0;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      step(s.b, s.v, s.rl, 1'b0);
      total_cnt++;
      if (ifc.locked_o !== e_locked || ifc.v_o !== e_v || ifc.data_o !== e_data || (e_v && ifc.err_o !== e_err))
        $display("FAIL offset bit %0d: got %s want %s", n, got_s(), want_s());
      else pass_cnt++;
      if (n == 41 || n == 42) begin
        total_cnt++;
        if (ifc.locked_o !== (n == 42)) $display("FAIL offset_rise bit %0d: locked=%b want %b", n, ifc.locked_o, (n == 42));
        else pass_cnt++;
      end
      if (ifc.v_o === 1'b1) begin
        strobes++;
        total_cnt++;
        if (ifc.data_o !== 10'h343) $display("FAIL offset_data bit %0d: data=%h want 343", n, ifc.data_o);
        else pass_cnt++;
      end
      n++;
    end
    total_cnt++;
    if (strobes !== 4) $display("FAIL offset_strobes: got %0d want 4", strobes);
    else pass_cnt++;
  endtask

  // Ends locked with the stream aligned to a symbol boundary.
  task automatic test_false_candidate();
    stim_t s;
    int n, strobes, early;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    add_sym(10'h343);
    add_sym(10'h3E0);
    for (int i = 0; i < 13; i++) push_bit(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) add_sym(10'h343);
    n = 0; strobes = 0; early = 0;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      step(s.b, s.v, s.rl, 1'b0);
      total_cnt++;
      if (ifc.locked_o !== e_locked || ifc.v_o !== e_v || ifc.data_o !== e_data || (e_v && ifc.err_o !== e_err))
        $display("FAIL false_cand bit %0d: got %s want %s", n, got_s(), want_s());
      else pass_cnt++;
      if (n < 72 && ifc.locked_o !== 1'b0) early++;
      if (n == 72) begin
        total_cnt++;
        if (ifc.locked_o !== 1'b1) $display("FAIL false_cand_lock bit 72: locked=%b want 1", ifc.locked_o);
        else pass_cnt++;
      end
      if (ifc.v_o === 1'b1) begin
        strobes++;
        total_cnt++;
        if (ifc.data_o !== 10'h343) $display("FAIL false_cand_data bit %0d: data=%h want 343", n, ifc.data_o);
        else pass_cnt++;
      end
      n++;
    end
    total_cnt++;
    if (early !== 0 || strobes !== 4)
      $display("FAIL false_cand_phase: early-lock cycles=%0d strobes=%0d want 0 and 4", early, strobes);
    else pass_cnt++;
  endtask

  // Continues from the aligned lock left by test_false_candidate.
  task automatic test_error_tolerance();
    stim_t s;
    int n, k;
    logic [9:0] want_d;
    logic want_e, want_l;
    for (int i = 0; i < 3; i++) add_sym(10'h3E0);
    for (int i = 0; i < 3; i++) add_sym(10'h343);
    for (int i = 0; i < 4; i++) add_sym(10'h3E0);
    for (int i = 0; i < 2; i++) add_sym(10'h343);
    n = 0; k = 0;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      step(s.b, s.v, s.rl, 1'b0);
      total_cnt++;
      if (ifc.locked_o !== e_locked || ifc.v_o !== e_v || ifc.data_o !== e_data || (e_v && ifc.err_o !== e_err))
        $display("FAIL err_tol bit %0d: got %s want %s", n, got_s(), want_s());
      else pass_cnt++;
      if (ifc.v_o === 1'b1) begin
        k++;
        want_e = !(k >= 4 && k <= 6);
        want_d = want_e ? 10'h3E0 : 10'h343;
        want_l = (k != 10);
        total_cnt++;
        if (ifc.data_o !== want_d || ifc.err_o !== want_e || ifc.locked_o !== want_l)
          $display("FAIL err_tol_sym %0d: data=%h err=%b lock=%b want %h/%b/%b",
                   k, ifc.data_o, ifc.err_o, ifc.locked_o, want_d, want_e, want_l);
        else pass_cnt++;
      end
      n++;
    end
    total_cnt++;
    if (k !== 10 || ifc.locked_o !== 1'b0) $display("FAIL err_tol_count: strobes=%0d lock=%b want 10/0", k, ifc.locked_o);
    else pass_cnt++;
  endtask

  task automatic test_stall();
    stim_t s;
    int n, strobes, acc, stall_v;
    logic [9:0] sym;
    sym = 10'h343;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) add_sym(sym);
    for (int i = 9; i >= 7; i--) push_bit(sym[i], 1'b1, 1'b0);
    add_idle(7);
    for (int i = 6; i >= 0; i--) push_bit(sym[i], 1'b1, 1'b0);
    add_sym(sym);
    for (int i = 9; i >= 6; i--) push_bit(sym[i], 1'b1, 1'b0);
    n = 0; strobes = 0; acc = 0; stall_v = 0;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      step(s.b, s.v, s.rl, 1'b0);
      if (s.v) acc++;
      else if (ifc.v_o !== 1'b0) stall_v++;
      total_cnt++;
      if (ifc.locked_o !== e_locked || ifc.v_o !== e_v || ifc.data_o !== e_data || (e_v && ifc.err_o !== e_err))
        $display("FAIL stall cyc %0d: got %s want %s", n, got_s(), want_s());
      else pass_cnt++;
      if (ifc.v_o === 1'b1) begin
        if (strobes > 0) begin
          total_cnt++;
          if (acc !== 10 || ifc.data_o !== 10'h343)
            $display("FAIL stall_spacing: bits between strobes=%0d data=%h want 10/343", acc, ifc.data_o);
          else pass_cnt++;
        end
        strobes++;
        acc = 0;
      end
      n++;
    end
    total_cnt++;
    if (stall_v !== 0 || strobes !== 3) $display("FAIL stall_strobes: during-stall=%0d total=%0d want 0/3", stall_v, strobes);
    else pass_cnt++;
    // Reset in the middle of a locked symbol.
    step(1'b1, 1'b1, 1'b0, 1'b1);
    total_cnt++;
    if ({ifc.locked_o, ifc.v_o, ifc.err_o, ifc.data_o} !== 13'h0)
      $display("FAIL reset_mid_lock: got %s, required all zero", got_s());
    else pass_cnt++;
  endtask

  task automatic test_realign();
    stim_t s;
    int n;
    logic [9:0] sym;
    sym = 10'h343;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) add_sym(sym);
    for (int i = 9; i >= 1; i--) push_bit(sym[i], 1'b1, (i == 1));
    push_bit(sym[0], 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) add_sym(sym);
    for (int i = 9; i >= 0; i--) push_bit(sym[i], 1'b1, (i == 0));
    n = 0;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      step(s.b, s.v, s.rl, 1'b0);
      total_cnt++;
      if (ifc.locked_o !== e_locked || ifc.v_o !== e_v || ifc.data_o !== e_data || (e_v && ifc.err_o !== e_err))
        $display("FAIL realign bit %0d: got %s want %s", n, got_s(), want_s());
      else pass_cnt++;
      if (n == 57 || n == 58 || n == 88 || n == 89) begin
        total_cnt++;
        if (ifc.locked_o !== (n == 57 || n == 89))
          $display("FAIL realign_lock bit %0d: locked=%b want %b", n, ifc.locked_o, (n == 57 || n == 89));
        else pass_cnt++;
      end
      if (n == 99 || n == 109) begin
        total_cnt++;
        if (ifc.v_o !== (n == 99) || ifc.locked_o !== (n == 99) || ifc.data_o !== 10'h343)
          $display("FAIL realign_emit bit %0d: v=%b lock=%b data=%h", n, ifc.v_o, ifc.locked_o, ifc.data_o);
        else pass_cnt++;
      end
      n++;
    end
  endtask

  task automatic test_random();
    stim_t s;
    int n, strobes, errs;
    logic [9:0] sym, cur;
    n = 0; strobes = 0; errs = 0;
    for (int r = 0; r < 20; r++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1);
      do sym = 10'($urandom_range(0, 1023)); while (!m_valid(sym));
      add_idle(int'($urandom_range(0, 9)) < 3 ? int'($urandom_range(0, 9)) : 0);
      for (int j = 0; j < 14; j++) begin
        cur = ($urandom_range(0, 9) == 0) ? 10'($urandom_range(0, 1023)) : sym;
        for (int i = 9; i >= 0; i--) begin
          if ($urandom_range(0, 4) == 0) add_idle(int'($urandom_range(1, 3)));
          push_bit(cur[i], 1'b1, ($urandom_range(0, 199) == 0));
        end
      end
      while (stim_q.size() > 0) begin
        s = stim_q.pop_front();
        step(s.b, s.v, s.rl, 1'b0);
        total_cnt++;
        if (ifc.locked_o !== e_locked || ifc.v_o !== e_v || ifc.data_o !== e_data || (e_v && ifc.err_o !== e_err))
          $display("FAIL random round %0d cyc %0d: got %s want %s", r, n, got_s(), want_s());
        else pass_cnt++;
        if (ifc.v_o === 1'b1) begin
          strobes++;
          if (ifc.err_o === 1'b1) errs++;
        end
        n++;
      end
    end
    total_cnt++;
    if (strobes < 20) $display("FAIL random_activity: only %0d strobes (%0d with err)", strobes, errs);
    else pass_cnt++;
  endtask

  initial begin
    reset = 1'b1;
    ifc.bit_i = 1'b0;
    ifc.v_i = 1'b0;
    ifc.realign_i = 1'b0;
    model_update(1'b0, 1'b0, 1'b0, 1'b1);
    test_reset();
    test_clean_lock();
    test_offset();
    test_false_candidate();
    test_error_tolerance();
    test_stall();
    test_realign();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
